ex_mem_ff: RTL and testbench

//  EX/MEM pipeline register of the 5-stage 64-bit ARM (LEGv8) pipelined CPU.
//  - Captures the execute-stage ALU result, store data, destination register and memory/writeback controls.
//  - Presents them to the memory stage one clock later.
//  - Built from generic synchronous-reset D flip-flops, the same primitive family as DFF64 / DFFwithEnable.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/dff_sync.sv | 33 +++
 rtl/ex_mem_ff.sv | 79 +++++++
 tb/tb_ex_mem_ff.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared widths and the packed EX/MEM bundle for the LEGv8 pipeline.
// Field order in ex_mem_t matches the concatenation order used by the pipeline and bench.
package cpu_pkg;

   localparam int DATA_W = 64;
   localparam int REG_W  = 5;
   localparam int XFER_W = 4;

   localparam int EX_MEM_W = 2 * DATA_W + REG_W + 4 + XFER_W;

   typedef struct packed {
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] data;
      logic [REG_W-1:0]  rd;
      logic              reg_wr;
      logic              mem_wr;
      logic              mem_rd;
      logic              ldurb;
      logic [XFER_W-1:0] xfer;
   } ex_mem_t;

endpackage

// File: rtl/dff_sync.sv
// Generic W-bit D flip-flop with synchronous active-high clear and load enable.
// Clear wins over enable so a reset cycle always yields a zero word.
module dff_sync #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         enable,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (enable) begin
         q_d = d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/ex_mem_ff.sv
// EX/MEM pipeline register: one-cycle, stall-free copy of execute-stage results and controls.
// A reset cycle produces an all-zero bubble (no memory or register write downstream).
module ex_mem_ff #(
   parameter int DATA_W = cpu_pkg::DATA_W,
   parameter int REG_W  = cpu_pkg::REG_W,
   parameter int XFER_W = cpu_pkg::XFER_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] alu_out,
   input  logic [REG_W-1:0]  outRd,
   input  logic [DATA_W-1:0] outDataIn,
   input  logic              reg_wr,
   input  logic              mem_wr,
   input  logic              mem_rd,
   input  logic              ldurb,
   input  logic [XFER_W-1:0] transfer,
   output logic [DATA_W-1:0] aluMem,
   output logic [DATA_W-1:0] dataInMem,
   output logic [REG_W-1:0]  rdMem,
   output logic              reg_wr_mem,
   output logic              mem_wr_mem,
   output logic              mem_rd_mem,
   output logic              ldurb_mem,
   output logic [XFER_W-1:0] transfer_mem
);

   // The four 1-bit controls share one register; bit order is reg_wr, mem_wr, mem_rd, ldurb.
   logic [3:0] ctrl_d;
   logic [3:0] ctrl_q;

   assign ctrl_d = {reg_wr, mem_wr, mem_rd, ldurb};

   dff_sync #(.W(DATA_W)) u_alu (
      .clk    (clk),
      .reset  (reset),
      .enable (1'b1),
      .d      (alu_out),
      .q      (aluMem)
   );

   dff_sync #(.W(DATA_W)) u_data (
      .clk    (clk),
      .reset  (reset),
      .enable (1'b1),
      .d      (outDataIn),
      .q      (dataInMem)
   );

   dff_sync #(.W(REG_W)) u_rd (
      .clk    (clk),
      .reset  (reset),
      .enable (1'b1),
      .d      (outRd),
      .q      (rdMem)
   );

   dff_sync #(.W(4)) u_ctrl (
      .clk    (clk),
      .reset  (reset),
      .enable (1'b1),
      .d      (ctrl_d),
      .q      (ctrl_q)
   );

   dff_sync #(.W(XFER_W)) u_xfer (
      .clk    (clk),
      .reset  (reset),
      .enable (1'b1),
      .d      (transfer),
      .q      (transfer_mem)
   );

   assign reg_wr_mem = ctrl_q[3];
   assign mem_wr_mem = ctrl_q[2];
   assign mem_rd_mem = ctrl_q[1];
   assign ldurb_mem  = ctrl_q[0];

endmodule

// File: tb/tb_ex_mem_ff.sv
// Directed testbench for ex_mem_ff: reset, capture latency, streaming, mid-run reset,
// between-edge stability and walking-one field isolation.
module tb_ex_mem_ff;
   import cpu_pkg::*;

   logic    clk;
   logic    reset;
   ex_mem_t in_v;
   ex_mem_t out_v;
   ex_mem_t exp_v;
   ex_mem_t hold_v;

   logic [DATA_W-1:0] aluMem;
   logic [DATA_W-1:0] dataInMem;
   logic [REG_W-1:0]  rdMem;
   logic              reg_wr_mem;
   logic              mem_wr_mem;
   logic              mem_rd_mem;
   logic              ldurb_mem;
   logic [XFER_W-1:0] transfer_mem;

   int vectors;
   int miscompares;

   ex_mem_ff dut (
      .clk          (clk),
      .reset        (reset),
      .alu_out      (in_v.alu),
      .outRd        (in_v.rd),
      .outDataIn    (in_v.data),
      .reg_wr       (in_v.reg_wr),
      .mem_wr       (in_v.mem_wr),
      .mem_rd       (in_v.mem_rd),
      .ldurb        (in_v.ldurb),
      .transfer     (in_v.xfer),
      .aluMem       (aluMem),
      .dataInMem    (dataInMem),
      .rdMem        (rdMem),
      .reg_wr_mem   (reg_wr_mem),
      .mem_wr_mem   (mem_wr_mem),
      .mem_rd_mem   (mem_rd_mem),
      .ldurb_mem    (ldurb_mem),
      .transfer_mem (transfer_mem)
   );

   assign out_v = {aluMem, dataInMem, rdMem, reg_wr_mem, mem_wr_mem, mem_rd_mem, ldurb_mem, transfer_mem};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic edge_settle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      in_v  = '{alu: 64'hFFFF_FFFF_FFFF_FFFF, data: 64'hFFFF_FFFF_FFFF_FFFF, rd: 5'd31,
                reg_wr: 1'b1, mem_wr: 1'b1, mem_rd: 1'b1, ldurb: 1'b1, xfer: 4'hF};
      reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         edge_settle();
         vectors++;
         if (out_v !== '0) begin
            miscompares++;
            $display("FAIL reset_edge%0d got=%h exp=0", k, out_v);
         end else $display("vec %0d reset_edge%0d out=%h", vectors, k, out_v);
      end
   endtask

   task automatic test_capture();
      reset = 1'b0;
      in_v  = '{alu: 64'h0000_0000_0000_0010, data: 64'hDEAD_BEEF_CAFE_F00D, rd: 5'd3,
                reg_wr: 1'b0, mem_wr: 1'b1, mem_rd: 1'b0, ldurb: 1'b0, xfer: 4'd8};
      exp_v = in_v;
      #2;
      vectors++;
      if (out_v !== '0) begin
         miscompares++;
         $display("FAIL capture_pre_edge got=%h exp=0", out_v);
      end else $display("vec %0d capture_pre_edge out=%h", vectors, out_v);
      edge_settle();
      vectors++;
      if (out_v !== exp_v) begin
         miscompares++;
         $display("FAIL capture_post_edge got=%h exp=%h", out_v, exp_v);
      end else $display("vec %0d capture_post_edge out=%h", vectors, out_v);
   endtask

   task automatic test_back_to_back();
      ex_mem_t seq [3];
      seq[0] = '{alu: 64'h0000_0000_0000_1000, data: 64'h1111_2222_3333_4444, rd: 5'd9,
                 reg_wr: 1'b1, mem_wr: 1'b0, mem_rd: 1'b1, ldurb: 1'b0, xfer: 4'd8};
      seq[1] = '{alu: 64'h0000_0000_0000_1003, data: 64'h5555_6666_7777_8888, rd: 5'd10,
                 reg_wr: 1'b1, mem_wr: 1'b0, mem_rd: 1'b1, ldurb: 1'b1, xfer: 4'd1};
      seq[2] = '{alu: 64'h8000_0000_0000_0001, data: 64'h0, rd: 5'd31,
                 reg_wr: 1'b1, mem_wr: 1'b0, mem_rd: 1'b0, ldurb: 1'b0, xfer: 4'd0};
      for (int k = 0; k < 3; k++) begin
         in_v = seq[k];
         edge_settle();
         vectors++;
         if (out_v !== seq[k]) begin
            miscompares++;
            $display("FAIL b2b_%0d got=%h exp=%h", k, out_v, seq[k]);
         end else $display("vec %0d b2b_%0d out=%h", vectors, k, out_v);
      end
   endtask

   task automatic test_midrun_reset();
      in_v = '{alu: 64'h0123_4567_89AB_CDEF, data: 64'hFEDC_BA98_7654_3210, rd: 5'd7,
               reg_wr: 1'b1, mem_wr: 1'b1, mem_rd: 1'b0, ldurb: 1'b0, xfer: 4'd8};
      reset = 1'b1;
      edge_settle();
      vectors++;
      if (out_v !== '0) begin
         miscompares++;
         $display("FAIL midrun_reset got=%h exp=0", out_v);
      end else $display("vec %0d midrun_reset out=%h", vectors, out_v);
      reset = 1'b0;
      in_v  = '{alu: 64'hA5A5_A5A5_5A5A_5A5A, data: 64'h0F0F_F0F0_0F0F_F0F0, rd: 5'd21,
                reg_wr: 1'b0, mem_wr: 1'b1, mem_rd: 1'b1, ldurb: 1'b1, xfer: 4'd2};
      exp_v = in_v;
      edge_settle();
      vectors++;
      if (out_v !== exp_v) begin
         miscompares++;
         $display("FAIL midrun_resume got=%h exp=%h", out_v, exp_v);
      end else $display("vec %0d midrun_resume out=%h", vectors, out_v);
   endtask

   task automatic test_between_edges();
      hold_v = exp_v;
      in_v   = '{alu: 64'h1, data: 64'h2, rd: 5'd1, reg_wr: 1'b1, mem_wr: 1'b0,
                 mem_rd: 1'b0, ldurb: 1'b1, xfer: 4'd4};
      reset  = 1'b1;
      #3;
      reset  = 1'b0;
      in_v   = '{alu: 64'hCAFE_0000_0000_BABE, data: 64'h7777_0000_0000_7777, rd: 5'd17,
                 reg_wr: 1'b0, mem_wr: 1'b0, mem_rd: 1'b1, ldurb: 1'b0, xfer: 4'd2};
      #3;
      vectors++;
      if (out_v !== hold_v) begin
         miscompares++;
         $display("FAIL between_edges_hold got=%h exp=%h", out_v, hold_v);
      end else $display("vec %0d between_edges_hold out=%h", vectors, out_v);
      exp_v = in_v;
      edge_settle();
      vectors++;
      if (out_v !== exp_v) begin
         miscompares++;
         $display("FAIL between_edges_next got=%h exp=%h", out_v, exp_v);
      end else $display("vec %0d between_edges_next out=%h", vectors, out_v);
   endtask

   task automatic test_walking_one();
      // Positions 0..140 of the packed bundle cover every field bit exactly once.
      for (int b = 0; b < EX_MEM_W; b++) begin
         in_v     = '0;
         in_v[b]  = 1'b1;
         exp_v    = '0;
         exp_v[b] = 1'b1;
         edge_settle();
         vectors++;
         if (out_v !== exp_v) begin
            miscompares++;
            $display("FAIL walk_bit%0d got=%h exp=%h", b, out_v, exp_v);
         end else $display("vec %0d walk_bit%0d ok", vectors, b);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      in_v        = '0;
      test_reset();
      test_capture();
      test_back_to_back();
      test_midrun_reset();
      test_between_edges();
      test_walking_one();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
